fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage and program-counter owner for the MIPS-31 core. It fetches the instruction at PC from instruction memory over a req/ready handshake and presents it to the decoder and controller. It then waits for the datapath to acknowledge execution. On acknowledge, it applies the controller's next-PC selection (sequential, branch, jump, or jump-register) and starts the next fetch. It sits directly upstream of the decoder/controller and consumes the controller's PC-select decisions.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; always equals pc.
imem_ready  input  1  instruction memory has imem_rdata valid this cycle.
imem_rdata  input  32  instruction word from memory.
instr  output  32  latched instruction presented to the decoder.
pc  output  32  address of the current instruction.
pc_plus4  output  32  pc + 4, modulo 2^32; also used as the jal link value.
instr_valid  output  1  instr and pc are valid and held stable.
instr_ack  input  1  datapath has executed instr; sample the select inputs now.
branch_taken  input  1  beq/bne condition resolved as taken.
jump_en  input  1  j/jal: take the concatenated target.
jr_en  input  1  jr: take rs_data.
rs_data  input  32  register rs value used as the jr target.
misalign  output  1  sticky fault: a computed next PC had bits [1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, pc = RESET_PC, instr = 0.
  - imem_req = 0, instr_valid = 0, misalign = 0.
  - A reset asserted mid-operation takes effect immediately and drops imem_req and instr_valid asynchronously.
- State machine: IDLE, FETCH, HOLD, FAULT.
- IDLE: outputs idle. Moves unconditionally to FETCH on the next edge.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - While imem_ready = 0, stay in FETCH; pc and instr are unchanged.
  - On a cycle with imem_ready = 1: instr <= imem_rdata and state <= HOLD.
- HOLD:
  - instr_valid = 1 and imem_req = 0. instr and pc are held stable.
  - The select inputs are ignored unless instr_ack = 1.
  - On a cycle with instr_ack = 1, compute next_pc with fixed priority:
    - jr_en: next_pc = rs_data.
    - else jump_en: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00}.
    - else branch_taken: next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} (EXT18, signed, modulo 2^32).
    - else next_pc = pc_plus4.
  - If next_pc[1:0] == 0: pc <= next_pc and state <= FETCH.
  - Otherwise: state <= FAULT, misalign <= 1, and pc is unchanged.
- FAULT:
  - imem_req = 0, instr_valid = 0, misalign = 1.
  - Leaves FAULT only on reset.
- Timing:
  - With imem_ready already high in FETCH, each instruction takes 2 cycles (FETCH, then HOLD with ack).
  - The next imem_req rises on the cycle after the ack.
  - instr_valid rises on the cycle after the imem_ready handshake.
- Ignored inputs: imem_ready outside FETCH, and instr_ack outside HOLD, have no effect.
- Simultaneous selects: if several of jr_en, jump_en, and branch_taken are high, the priority above decides. Only jr_en can produce a misaligned target; jump and branch targets are always word-aligned.
- Wrap-around: pc = 32'hFFFF_FFFC with sequential flow gives next pc = 0, with no fault. Branch targets wrap the same way.
- pc_plus4 is combinational from pc and is valid in every state.

Test Plan:
- Reset then sequential flow: release rst, tie imem_ready = 1, ack every HOLD → imem_addr sequence 0x00400000, 0x00400004, 0x00400008; instr_valid high on alternate cycles.
- Memory wait states: hold imem_ready low for 3 cycles in the first FETCH, return 0x2402_0005 → imem_req high for 4 cycles; instr = 0x2402_0005 and instr_valid = 1 on the 5th cycle; pc stays 0x00400000 throughout.
- Backward branch: pc = 0x00400010, instr = 0x1000_FFFC, branch_taken = 1, ack → next imem_addr = 0x00400004.
- Jump vs branch priority: pc = 0x00400020, instr = 0x0810_0040, jump_en = 1 and branch_taken = 1, ack → pc = 0x00400100.
- jr misalign: jr_en = 1, rs_data = 0x0040_0006, ack → misalign = 1, FAULT, imem_req stays 0, pc unchanged. Asserting rst → pc = 0x00400000 and misalign = 0.
- Reset mid-fetch: assert rst while FETCH is waiting on imem_ready → imem_req drops in the same cycle; after release, the first fetch address is 0x00400000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// holds the instruction until the datapath acknowledges, then selects the next PC.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic        jump_en,
    input  logic        jr_en,
    input  logic [31:0] rs_data,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_valid;
    logic        r_misalign;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jump_tgt = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Fixed priority: jr over jump over branch over sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr_en)
            w_next_pc = rs_data;
        else if (jump_en)
            w_next_pc = w_jump_tgt;
        else if (branch_taken)
            w_next_pc = w_pc_plus4 + w_br_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= HOLD;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ack) begin
                        r_valid <= 1'b0;
                        if (w_next_pc[1:0] == 2'b00) begin
                            r_pc    <= w_next_pc;
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                        end else begin
                            r_state    <= FAULT;
                            r_misalign <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    r_req      <= 1'b0;
                    r_valid    <= 1'b0;
                    r_misalign <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized instruction flow
// checked against a transaction-level PC model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch_taken;
    logic        jump_en;
    logic        jr_en;
    logic [31:0] rs_data;
    logic        misalign;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .instr_ack(instr_ack),
        .branch_taken(branch_taken), .jump_en(jump_en), .jr_en(jr_en),
        .rs_data(rs_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] m_pc;
    bit          faulted;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Next PC derived directly from the ISA rules with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input bit br, input bit j, input bit jr,
                                             input logic [31:0] rs);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = cur + 32'd4;
        imm = word[15:0];
        off = imm;
        if (jr) return rs;
        if (j)  return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (br) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0; imem_rdata = 32'd0; instr_ack = 1'b0;
        branch_taken = 1'b0; jump_en = 1'b0; jr_en = 1'b0; rs_data = 32'd0;
    endtask

    // Called at a negedge; asserts reset mid-cycle and leaves the DUT in FETCH.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check32("rst_req_async", imem_req, 0);
        check32("rst_valid_async", instr_valid, 0);
        @(negedge clk);
        idle_inputs();
        check32("rst_pc", pc, RESET_PC);
        check32("rst_instr", instr, 0);
        check32("rst_misalign", misalign, 0);
        rst = 1'b0;
        m_pc = RESET_PC;
        faulted = 0;
        step();
    endtask

    // One instruction: fetch with wait states, hold, then acknowledge with selects.
    task automatic do_instr(input logic [31:0] word, input int waits, input int holds,
                            input bit br, input bit j, input bit jr, input logic [31:0] rs);
        logic [31:0] nxt;
        check32("fetch_req", imem_req, 1);
        check32("fetch_addr", imem_addr, m_pc);
        check32("fetch_valid", instr_valid, 0);
        for (int k = 0; k < waits; k++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            instr_ack  = 1'($urandom_range(0, 1));
            step();
            check32("wait_req", imem_req, 1);
            check32("wait_pc", pc, m_pc);
            check32("wait_valid", instr_valid, 0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        instr_ack  = 1'b0;
        step();
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        check32("hold_valid", instr_valid, 1);
        check32("hold_req", imem_req, 0);
        check32("hold_instr", instr, word);
        check32("hold_pc", pc, m_pc);
        check32("hold_pc4", pc_plus4, m_pc + 32'd4);
        for (int k = 0; k < holds; k++) begin
            instr_ack    = 1'b0;
            branch_taken = 1'($urandom_range(0, 1));
            jump_en      = 1'($urandom_range(0, 1));
            jr_en        = 1'($urandom_range(0, 1));
            rs_data      = $urandom;
            step();
            check32("hold_stable_instr", instr, word);
            check32("hold_stable_pc", pc, m_pc);
            check32("hold_stable_valid", instr_valid, 1);
        end
        instr_ack = 1'b1; branch_taken = br; jump_en = j; jr_en = jr; rs_data = rs;
        step();
        idle_inputs();
        nxt = ref_next(m_pc, word, br, j, jr, rs);
        if (nxt[1:0] != 2'b00) begin
            for (int k = 0; k < 3; k++) begin
                check32("fault_misalign", misalign, 1);
                check32("fault_req", imem_req, 0);
                check32("fault_valid", instr_valid, 0);
                check32("fault_pc", pc, m_pc);
                imem_ready = 1'($urandom_range(0, 1));
                instr_ack  = 1'($urandom_range(0, 1));
                step();
            end
            idle_inputs();
            faulted = 1;
        end else begin
            m_pc = nxt;
            check32("ack_misalign", misalign, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] rs;
        int          kind;
        idle_inputs();
        rst = 1'b1;
        faulted = 0;
        @(negedge clk);
        check32("init_req", imem_req, 0);
        check32("init_valid", instr_valid, 0);
        check32("init_pc", pc, RESET_PC);
        check32("init_instr", instr, 0);
        check32("init_misalign", misalign, 0);
        rst = 1'b0;
        m_pc = RESET_PC;
        step();

        // Sequential flow with memory always ready.
        for (int i = 0; i < 3; i++) begin
            check32("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
            do_instr($urandom, 0, 0, 0, 0, 0, 32'd0);
        end

        // Reset while FETCH waits on memory, then wait-state fetch from reset PC.
        imem_ready = 1'b0;
        step();
        do_reset();
        check32("mid_rst_addr", imem_addr, 32'h0040_0000);
        do_instr(32'h2402_0005, 3, 0, 0, 0, 0, 32'd0);

        // Backward branch from 0x00400010.
        do_instr($urandom, 0, 0, 0, 0, 1, 32'h0040_0010);
        do_instr(32'h1000_FFFC, 0, 1, 1, 0, 0, 32'd0);
        check32("bwd_branch_addr", imem_addr, 32'h0040_0004);

        // Jump wins over branch from 0x00400020.
        do_instr($urandom, 0, 0, 0, 0, 1, 32'h0040_0020);
        do_instr(32'h0810_0040, 1, 0, 1, 1, 0, 32'd0);
        check32("jump_prio_addr", imem_addr, 32'h0040_0100);

        // Wrap-around: sequential and branch.
        do_instr($urandom, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        do_instr($urandom & 32'h03FF_FFFF, 0, 0, 0, 0, 0, 32'd0);
        check32("wrap_seq_addr", imem_addr, 32'h0000_0000);
        do_instr(32'h1000_FFFE, 0, 0, 1, 0, 0, 32'd0);
        check32("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);

        // Misaligned jr faults, reset recovers.
        do_instr($urandom, 0, 0, 0, 0, 0, 32'd0);
        do_instr($urandom, 0, 0, 0, 0, 1, 32'h0040_0006);
        do_reset();
        check32("post_fault_pc", pc, 32'h0040_0000);
        check32("post_fault_misalign", misalign, 0);

        // Randomized flow.
        for (int n = 0; n < 300; n++) begin
            if (faulted) do_reset();
            w    = $urandom;
            rs   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) rs = rs | 32'(1 + $urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            do_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                     kind inside {[4:6], 9}, kind inside {[7:8], 9}, kind == 9 || kind == 3,
                     rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
